// File: rtl/rgmii_rx_speed_adapt.sv
// rgmii_rx_speed_adapt
// Tri-speed RGMII receive post-processor sitting between the IDDR capture stage and
// the MAC. Decodes debounced in-band link status, passes gigabit bytes straight
// through and assembles nibble pairs into strobed bytes at 10/100, flagging frames
// that end on an odd nibble.
// Optional feature macro: RGMII_RX_STATS_EN (frame / error statistics counters).
module rgmii_rx_speed_adapt #(
  parameter int STATUS_STABLE = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 rx_clk,
  input  logic                 rst_n,
  input  logic [3:0]           rxd_rise,
  input  logic [3:0]           rxd_fall,
  input  logic                 rx_ctl_rise,
  input  logic                 rx_ctl_fall,
  input  logic [2:0]           speed_override,
  output logic [7:0]           gmii_rxd,
  output logic                 gmii_rx_dv,
  output logic                 gmii_rx_er,
  output logic                 gmii_rx_ce,
  output logic                 link_up,
  output logic [1:0]           link_speed,
  output logic                 full_duplex,
  output logic                 status_change,
  input  logic                 stats_clr,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam int SCW = $clog2(STATUS_STABLE + 1);
  localparam logic [SCW-1:0] STABLE = SCW'(STATUS_STABLE);

  typedef enum logic {PH_LOW = 1'b0, PH_HIGH = 1'b1} phase_t;

  // RX_CTL decode: rising half is DV, falling half carries DV^ER
  logic dv_i, er_i, dv_rise;
  logic dv_prev_reg;
  assign dv_i    = rx_ctl_rise;
  assign er_i    = rx_ctl_rise ^ rx_ctl_fall;
  assign dv_rise = dv_i & ~dv_prev_reg;

  // ---------------------------------------------------------------------------
  // In-band status debounce
  // ---------------------------------------------------------------------------
  logic [3:0]     samp_reg, samp_next;
  logic [SCW-1:0] stab_cnt_reg, stab_cnt_next;
  logic [3:0]     status_cur, status_next;
  logic           change_next;

  assign status_cur = {full_duplex, link_speed, link_up};

  // Count consecutive identical idle samples; publish once stable and different
  always_comb begin
    samp_next     = samp_reg;
    stab_cnt_next = stab_cnt_reg;
    status_next   = status_cur;
    change_next   = 1'b0;
    if (!dv_i && !er_i) begin
      samp_next = rxd_rise;
      if (rxd_rise == samp_reg) begin
        if (stab_cnt_reg != STABLE) stab_cnt_next = stab_cnt_reg + SCW'(1);
      end else begin
        stab_cnt_next = SCW'(1);
      end
      if ((stab_cnt_next == STABLE) && (rxd_rise != status_cur)) begin
        status_next = rxd_rise;
        change_next = 1'b1;
      end
    end
  end

  // Status registers and the one-cycle change pulse
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_reg      <= 4'h0;
      stab_cnt_reg  <= '0;
      full_duplex   <= 1'b0;
      link_speed    <= 2'b00;
      link_up       <= 1'b0;
      status_change <= 1'b0;
    end else begin
      samp_reg      <= samp_next;
      stab_cnt_reg  <= stab_cnt_next;
      {full_duplex, link_speed, link_up} <= status_next;
      status_change <= change_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Active speed mode: only re-latched between frames
  // ---------------------------------------------------------------------------
  logic [1:0] mode_reg, mode_next, eff_speed;
  logic       slow;

  assign eff_speed = speed_override[2] ? speed_override[1:0] : link_speed;
  assign mode_next = dv_i ? mode_reg : eff_speed;
  assign slow      = ~mode_reg[1];

  // ---------------------------------------------------------------------------
  // Frame gating after reset: a frame already in progress at release is dropped,
  // output resumes on the next DV rising edge. dv_prev resets high so a DV that
  // is already asserted at release does not look like a rising edge.
  // ---------------------------------------------------------------------------
  logic wait_reg, wait_next, blocked;
  assign blocked   = wait_reg & ~dv_rise;
  assign wait_next = blocked;

  // ---------------------------------------------------------------------------
  // Nibble phase FSM (10/100 assembly)
  // ---------------------------------------------------------------------------
  phase_t phase_reg, phase_next;

  // Phase state register
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) phase_reg <= PH_LOW;
    else        phase_reg <= phase_next;
  end

  // Next phase: a frame start always restarts on the low nibble
  always_comb begin
    phase_next = PH_LOW;
    if (!blocked && slow && dv_i && (dv_rise || (phase_reg == PH_LOW)))
      phase_next = PH_HIGH;
  end

  // ---------------------------------------------------------------------------
  // Output datapath
  // ---------------------------------------------------------------------------
  logic [7:0] rxd_next;
  logic       dv_next, er_next, ce_next;
  logic [3:0] low_reg, low_next;
  logic       pend_reg, pend_next;
  logic       tog_reg, tog_next;

  // Output byte / strobe selection per mode and phase
  always_comb begin
    rxd_next  = gmii_rxd;
    dv_next   = gmii_rx_dv;
    er_next   = gmii_rx_er;
    ce_next   = 1'b0;
    low_next  = low_reg;
    pend_next = pend_reg;
    tog_next  = tog_reg;
    if (blocked) begin
      rxd_next = 8'h00;
      dv_next  = 1'b0;
      er_next  = 1'b0;
      tog_next = 1'b1;
    end else if (!slow) begin
      rxd_next = {rxd_fall, rxd_rise};
      dv_next  = dv_i;
      er_next  = er_i;
      ce_next  = 1'b1;
      tog_next = 1'b1;
    end else if (dv_i) begin
      tog_next = 1'b1;
      if (dv_rise || (phase_reg == PH_LOW)) begin
        low_next  = rxd_rise;
        pend_next = er_i;
      end else begin
        rxd_next = {rxd_rise, low_reg};
        dv_next  = 1'b1;
        er_next  = pend_reg | er_i;
        ce_next  = 1'b1;
      end
    end else if (phase_reg == PH_HIGH) begin
      // Frame ended on an odd nibble: flush it as an errored byte
      rxd_next = {4'h0, low_reg};
      dv_next  = 1'b1;
      er_next  = 1'b1;
      ce_next  = 1'b1;
      tog_next = 1'b1;
    end else if (er_i) begin
      rxd_next = {4'h0, rxd_rise};
      dv_next  = 1'b0;
      er_next  = 1'b1;
      ce_next  = 1'b1;
    end else begin
      // Idle strobe every other cycle keeps the MAC's byte timing
      ce_next  = tog_reg;
      tog_next = ~tog_reg;
      if (tog_reg) begin
        rxd_next = 8'h00;
        dv_next  = 1'b0;
        er_next  = 1'b0;
      end
    end
  end

  // Datapath, mode and frame-gating registers
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      gmii_rxd    <= 8'h00;
      gmii_rx_dv  <= 1'b0;
      gmii_rx_er  <= 1'b0;
      gmii_rx_ce  <= 1'b0;
      low_reg     <= 4'h0;
      pend_reg    <= 1'b0;
      tog_reg     <= 1'b1;
      mode_reg    <= 2'b10;
      wait_reg    <= 1'b1;
      dv_prev_reg <= 1'b1;
    end else begin
      gmii_rxd    <= rxd_next;
      gmii_rx_dv  <= dv_next;
      gmii_rx_er  <= er_next;
      gmii_rx_ce  <= ce_next;
      low_reg     <= low_next;
      pend_reg    <= pend_next;
      tog_reg     <= tog_next;
      mode_reg    <= mode_next;
      wait_reg    <= wait_next;
      dv_prev_reg <= dv_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef RGMII_RX_STATS_EN
  logic                 dv_out_d_reg, frame_err_reg, frame_end;
  logic [CNT_WIDTH-1:0] frame_cnt_reg, err_cnt_reg;

  assign frame_end = dv_out_d_reg & ~gmii_rx_dv;

  // Count frames on the assembled DV falling edge; errors once per frame
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_out_d_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      frame_cnt_reg <= '0;
      err_cnt_reg   <= '0;
    end else begin
      dv_out_d_reg <= gmii_rx_dv;
      if (frame_end)
        frame_err_reg <= 1'b0;
      else if (gmii_rx_ce && gmii_rx_dv && gmii_rx_er)
        frame_err_reg <= 1'b1;
      if (stats_clr) begin
        frame_cnt_reg <= '0;
        err_cnt_reg   <= '0;
      end else if (frame_end) begin
        if (frame_cnt_reg != '1) frame_cnt_reg <= frame_cnt_reg + CNT_WIDTH'(1);
        if (frame_err_reg && (err_cnt_reg != '1)) err_cnt_reg <= err_cnt_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign frame_cnt = frame_cnt_reg;
  assign err_cnt   = err_cnt_reg;
`else
  logic stats_unused;
  assign stats_unused = stats_clr;
  assign frame_cnt    = '0;
  assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_rgmii_rx_speed_adapt.sv
// tb_rgmii_rx_speed_adapt
// Directed bench for rgmii_rx_speed_adapt: gigabit pass-through, in-band status
// debounce, 100M nibble assembly, dribble flagging, mid-frame speed change and
// asynchronous reset mid-frame. Counter checks follow RGMII_RX_STATS_EN.
module tb_rgmii_rx_speed_adapt;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    rxd_rise, rxd_fall;
  logic          rx_ctl_rise, rx_ctl_fall;
  logic [2:0]    speed_override;
  logic          stats_clr;
  logic [7:0]    gmii_rxd;
  logic          gmii_rx_dv, gmii_rx_er, gmii_rx_ce;
  logic          link_up, full_duplex, status_change;
  logic [1:0]    link_speed;
  logic [CW-1:0] frame_cnt, err_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0] pre_bytes [10] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55,
                                 8'hD5, 8'h12, 8'h34};
  logic [7:0] drb_bytes [4]  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

  rgmii_rx_speed_adapt #(.STATUS_STABLE(4), .CNT_WIDTH(CW)) dut (
    .rx_clk         (clk),
    .rst_n          (rst_n),
    .rxd_rise       (rxd_rise),
    .rxd_fall       (rxd_fall),
    .rx_ctl_rise    (rx_ctl_rise),
    .rx_ctl_fall    (rx_ctl_fall),
    .speed_override (speed_override),
    .gmii_rxd       (gmii_rxd),
    .gmii_rx_dv     (gmii_rx_dv),
    .gmii_rx_er     (gmii_rx_er),
    .gmii_rx_ce     (gmii_rx_ce),
    .link_up        (link_up),
    .link_speed     (link_speed),
    .full_duplex    (full_duplex),
    .status_change  (status_change),
    .stats_clr      (stats_clr),
    .frame_cnt      (frame_cnt),
    .err_cnt        (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic dv, input logic er, input logic [3:0] r, input logic [3:0] f);
    rx_ctl_rise = dv;
    rx_ctl_fall = dv ^ er;
    rxd_rise    = r;
    rxd_fall    = f;
  endtask

  // One byte at 10/100: low nibble then high nibble; byte appears after the second
  task automatic slow_byte(input logic [7:0] b);
    drv(1'b1, 1'b0, b[3:0], 4'h0);
    tick();
    chk("slow_lo_ce", 32'(gmii_rx_ce), 32'(1'b0));
    drv(1'b1, 1'b0, b[7:4], 4'h0);
    tick();
    chk("slow_rxd", 32'(gmii_rxd), 32'(b));
    chk("slow_flags", 32'({gmii_rx_ce, gmii_rx_dv, gmii_rx_er}), 32'(3'b110));
  endtask

  task automatic chk_stats(input string tag, input int fexp, input int eexp);
`ifdef RGMII_RX_STATS_EN
    chk({tag, "_frames"}, 32'(frame_cnt), 32'(fexp));
    chk({tag, "_errs"},   32'(err_cnt),   32'(eexp));
`else
    chk({tag, "_frames"}, 32'(frame_cnt), 32'(0));
    chk({tag, "_errs"},   32'(err_cnt),   32'(0));
    if (fexp < 0 || eexp < 0) $display("note: negative stats expectation");
`endif
  endtask

  initial begin
    logic [7:0] b;
    rst_n          = 1'b0;
    speed_override = 3'b110;
    stats_clr      = 1'b0;
    drv(1'b0, 1'b0, 4'h0, 4'h0);
    tick();
    tick();

    // Reset state
    chk("rst_rxd", 32'(gmii_rxd), 32'(8'h00));
    chk("rst_flags", 32'({gmii_rx_ce, gmii_rx_dv, gmii_rx_er}), 32'(3'b000));
    chk("rst_status", 32'({link_up, link_speed, full_duplex, status_change}), 32'(5'b0));
    chk_stats("rst", 0, 0);
    #2 rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_ce", 32'(gmii_rx_ce), 32'(1'b0));

    // 1000M 64-byte frame: preamble, SFD, then data
    for (int k = 0; k < 64; k++) begin
      if (k < 7)       b = 8'h55;
      else if (k == 7) b = 8'hD5;
      else             b = 8'(k) ^ 8'hA0;
      drv(1'b1, 1'b0, b[3:0], b[7:4]);
      tick();
      chk("g_rxd", 32'(gmii_rxd), 32'(b));
      chk("g_flags", 32'({gmii_rx_ce, gmii_rx_dv, gmii_rx_er}), 32'(3'b110));
    end
    drv(1'b0, 1'b0, 4'h0, 4'h0);
    tick();
    chk("g_end", 32'({gmii_rx_ce, gmii_rx_dv, gmii_rx_er}), 32'(3'b100));
    $display("frame: 1000M 64 bytes");

    // 1000M short frame with er on second byte
    drv(1'b1, 1'b0, 4'h2, 4'h1);
    tick();
    chk("g_er_b0", 32'(gmii_rxd), 32'(8'h12));
    drv(1'b1, 1'b1, 4'h4, 4'h3);
    tick();
    chk("g_er_flags", 32'({gmii_rx_ce, gmii_rx_dv, gmii_rx_er}), 32'(3'b111));
    drv(1'b0, 1'b0, 4'h0, 4'h0);
    tick();
    chk("g_er_end", 32'({gmii_rx_ce, gmii_rx_dv, gmii_rx_er}), 32'(3'b100));
    $display("frame: 1000M 2 bytes with er");

    // False carrier at 1000M
    drv(1'b0, 1'b1, 4'hE, 4'h0);
    tick();
    chk("g_carrier_flags", 32'({gmii_rx_ce, gmii_rx_dv, gmii_rx_er}), 32'(3'b101));
    chk("g_carrier_rxd", 32'(gmii_rxd), 32'(8'h0E));
    drv(1'b0, 1'b0, 4'h0, 4'h0);
    tick();

    // In-band status: 1101 held four idle cycles
    drv(1'b0, 1'b0, 4'hD, 4'h0);
    tick();
    tick();
    tick();
    chk("st_early_link", 32'(link_up), 32'(1'b0));
    chk("st_early_chg", 32'(status_change), 32'(1'b0));
    tick();
    chk("st_update", 32'({full_duplex, link_speed, link_up}), 32'(4'b1101));
    chk("st_pulse", 32'(status_change), 32'(1'b1));
    tick();
    chk("st_pulse_end", 32'(status_change), 32'(1'b0));
    drv(1'b0, 1'b0, 4'h0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("st_glitch_chg", 32'(status_change), 32'(1'b0));
    end
    chk("st_glitch_hold", 32'({full_duplex, link_speed, link_up}), 32'(4'b1101));
    drv(1'b0, 1'b0, 4'hD, 4'h0);
    tick();
    tick();
    chk("st_after_glitch", 32'({full_duplex, link_speed, link_up, status_change}), 32'(5'b11010));
    $display("status: link up, 1000M, full duplex");

    // Switch to forced 100M; idle strobes every other cycle
    speed_override = 3'b101;
    tick();
    tick();
    chk("idle100_a", 32'({gmii_rx_ce, gmii_rx_dv, gmii_rxd}), 32'({2'b10, 8'h00}));
    tick();
    chk("idle100_b", 32'(gmii_rx_ce), 32'(1'b0));
    tick();
    chk("idle100_c", 32'(gmii_rx_ce), 32'(1'b1));

    // 100M frame: preamble nibbles, SFD D5, data 12 34
    for (int k = 0; k < 10; k++) slow_byte(pre_bytes[k]);
    drv(1'b0, 1'b0, 4'hD, 4'h0);
    tick();
    chk("s_end", 32'({gmii_rx_ce, gmii_rx_dv, gmii_rx_er}), 32'(3'b100));
    tick();
    chk("s_end_gap", 32'(gmii_rx_ce), 32'(1'b0));
    chk_stats("after_s", 3, 1);
    $display("frame: 100M 10 bytes");

    // 100M frame of nine nibbles -> dribble byte
    for (int k = 0; k < 4; k++) slow_byte(drb_bytes[k]);
    drv(1'b1, 1'b0, 4'h7, 4'h0);
    tick();
    chk("drb_odd_ce", 32'(gmii_rx_ce), 32'(1'b0));
    drv(1'b0, 1'b0, 4'hD, 4'h0);
    tick();
    chk("drb_rxd", 32'(gmii_rxd), 32'(8'h07));
    chk("drb_flags", 32'({gmii_rx_ce, gmii_rx_dv, gmii_rx_er}), 32'(3'b111));
    tick();
    chk("drb_end", 32'({gmii_rx_ce, gmii_rx_dv, gmii_rx_er}), 32'(3'b100));
    tick();
    chk_stats("sat", 3, 2);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk_stats("clr", 0, 0);
    $display("frame: 100M dribble");

    // Override 100M -> 1000M mid-frame
    drv(1'b1, 1'b0, 4'h1, 4'h0);
    tick();
    drv(1'b1, 1'b0, 4'h2, 4'h0);
    tick();
    chk("sw_b0", 32'(gmii_rxd), 32'(8'h21));
    speed_override = 3'b110;
    drv(1'b1, 1'b0, 4'h3, 4'h0);
    tick();
    chk("sw_still_slow", 32'(gmii_rx_ce), 32'(1'b0));
    drv(1'b1, 1'b0, 4'h4, 4'h0);
    tick();
    chk("sw_b1", 32'({gmii_rx_ce, gmii_rxd}), 32'({1'b1, 8'h43}));
    slow_byte(8'h65);
    drv(1'b0, 1'b0, 4'hD, 4'h0);
    tick();
    chk("sw_end_slow", 32'({gmii_rx_ce, gmii_rx_dv, gmii_rxd}), 32'({2'b10, 8'h00}));
    tick();
    chk("sw_idle_fast", 32'({gmii_rx_ce, gmii_rx_dv, gmii_rxd}), 32'({2'b10, 8'h0D}));
    drv(1'b1, 1'b0, 4'h9, 4'h8);
    tick();
    chk("sw_fast_byte", 32'({gmii_rx_ce, gmii_rx_dv, gmii_rxd}), 32'({2'b11, 8'h89}));
    drv(1'b0, 1'b0, 4'hD, 4'h0);
    tick();
    $display("frame: speed switch 100M -> 1000M");

    // 10M frame interrupted by asynchronous reset
    speed_override = 3'b100;
    tick();
    tick();
    slow_byte(8'h55);
    drv(1'b1, 1'b0, 4'h5, 4'h0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rxd", 32'(gmii_rxd), 32'(8'h00));
    chk("arst_flags", 32'({gmii_rx_ce, gmii_rx_dv, gmii_rx_er}), 32'(3'b000));
    chk("arst_status", 32'({link_up, link_speed, full_duplex}), 32'(4'b0));
    tick();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, 1'b0, 4'h5, 4'h0);
      tick();
      chk("arst_discard", 32'({gmii_rx_ce, gmii_rx_dv}), 32'(2'b00));
    end
    drv(1'b0, 1'b0, 4'hD, 4'h0);
    tick();
    chk("arst_idle_blocked", 32'(gmii_rx_ce), 32'(1'b0));
    drv(1'b1, 1'b0, 4'h6, 4'h0);
    tick();
    chk("arst_new_lo", 32'(gmii_rx_ce), 32'(1'b0));
    drv(1'b1, 1'b0, 4'h7, 4'h0);
    tick();
    chk("arst_new_byte", 32'({gmii_rx_ce, gmii_rx_dv, gmii_rx_er, gmii_rxd}), 32'({3'b110, 8'h76}));
    drv(1'b0, 1'b0, 4'hD, 4'h0);
    tick();
    chk("arst_new_end", 32'({gmii_rx_ce, gmii_rx_dv}), 32'(2'b10));
    tick();
    chk_stats("arst", 1, 0);
    $display("frame: 10M after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
